// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver, MSB first on the wire, sampled at bit centre.
// Delivers bytes on a valid/ready handshake and flags framing errors and overruns.
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int BIT_CNT  = CLK_FREQ / BAUD;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CW       = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_prev;
  logic [7:0]      r_rx_data;
  logic            r_rx_valid;
  logic            r_frame_err;
  logic            r_overrun;
  logic            w_fall;
  logic            w_tick;

  assign w_fall = r_prev & ~r_sync2;
  assign w_tick = (r_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rs232_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      // A deliver later in this block overrides the handshake clear.
      if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_fall) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd7;
            r_state   <= r_sync2 ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= r_sync2;
            if (r_bit_idx == 3'd0) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx - 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            if (!r_sync2) begin
              r_frame_err <= 1'b1;
            end else if (!r_rx_valid || rx_ready) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign rx_busy   = (r_state != S_IDLE);
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: frame-level reference model (expected event per frame at a
// fixed latency from the start edge) checked against the DUT every cycle.
module tb_uart_byte_rx;

  localparam int CLK_FREQ = 800_000;
  localparam int BAUD     = 100_000;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int HALF     = BIT / 2;
  // drive edge -> fall seen (2 sync + delay flop), half bit, 9 bit periods to stop centre
  localparam int LAT      = 3 + HALF + 9 * BIT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rs232_rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs232_rx (rs232_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_busy  (rx_busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ready_mode = 1;  // 0: low, 1: high, 2: random per cycle
  always @(posedge clk) begin
    #1;
    if (ready_mode == 2) rx_ready = 1'($urandom_range(0, 1));
    else                 rx_ready = (ready_mode == 1);
  end

  typedef struct {
    int         at;
    bit         ok;
    logic [7:0] d;
  } ev_t;

  ev_t        evq[$];
  bit         m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         m_ferr = 1'b0;
  bit         m_ovr = 1'b0;
  int         busy_lo = 0;
  int         busy_hi = 0;
  bit         ready_prev = 1'b0;
  bit         old_valid;
  bit         exp_busy;
  ev_t        e;

  int vectors = 0;
  int miscompares = 0;
  int n_prints = 0;

  int         n_rise = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  int         last_rise = 0;
  logic [7:0] rise_data = 8'h00;
  bit         prev_valid = 1'b0;
  int         last_k = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
      evq.delete();
      busy_lo = 0;
      busy_hi = 0;
    end else begin
      old_valid = m_valid;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (old_valid && ready_prev) m_valid = 1'b0;
      while (evq.size() > 0 && evq[0].at <= cyc) begin
        e = evq.pop_front();
        if (e.at != cyc) begin
          vectors++;
          miscompares++;
          $display("FAIL event_time: event due at cycle %0d seen at %0d", e.at, cyc);
        end else if (!e.ok) begin
          m_ferr = 1'b1;
        end else if (!old_valid || ready_prev) begin
          m_valid = 1'b1;
          m_data  = e.d;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    exp_busy = (cyc >= busy_lo) && (cyc < busy_hi);
    vectors++;
    if ({rx_valid, rx_data, rx_busy, frame_err, overrun} !==
        {m_valid, m_data, exp_busy, m_ferr, m_ovr}) begin
      miscompares++;
      if (n_prints < 20) begin
        n_prints++;
        $display("FAIL cycle %0d outputs valid/data/busy/ferr/ovr: got %b/%h/%b/%b/%b expected %b/%h/%b/%b/%b",
                 cyc, rx_valid, rx_data, rx_busy, frame_err, overrun,
                 m_valid, m_data, exp_busy, m_ferr, m_ovr);
      end
    end
    if (rx_valid === 1'b1 && !prev_valid) begin
      n_rise++;
      last_rise = cyc;
      rise_data = rx_data;
    end
    prev_valid = (rx_valid === 1'b1);
    if (frame_err === 1'b1) n_ferr++;
    if (overrun === 1'b1) n_ovr++;
    ready_prev = rx_ready;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit stop_ok, input int hold_low);
    int k;
    rs232_rx = 1'b0;
    k = cyc;
    last_k = k;
    busy_lo = k + 3;
    busy_hi = k + LAT;
    evq.push_back('{at: k + LAT, ok: stop_ok, d: d});
    tick(BIT);
    for (int i = 7; i >= 0; i--) begin
      rs232_rx = d[i];
      tick(BIT);
    end
    rs232_rx = stop_ok;
    tick(BIT);
    if (!stop_ok) begin
      tick(hold_low);
      rs232_rx = 1'b1;
      tick(BIT);
    end
  endtask

  task automatic glitch(input int width);
    int k;
    rs232_rx = 1'b0;
    k = cyc;
    busy_lo = k + 3;
    busy_hi = k + 3 + HALF;
    tick(width);
    rs232_rx = 1'b1;
    tick(2 * BIT);
  endtask

  int r0, f0, o0;

  initial begin
    tick(4);
    rst_n = 1'b1;

    // T1: idle line
    r0 = n_rise; f0 = n_ferr; o0 = n_ovr;
    tick(200);
    check("idle_no_valid", n_rise - r0, 0);
    check("idle_no_ferr", n_ferr - f0, 0);
    check("idle_busy", int'(rx_busy), 0);

    // T2: single byte, latency pinned
    r0 = n_rise;
    send(8'hA5, 1'b1, 0);
    tick(4);
    check("a5_count", n_rise - r0, 1);
    check("a5_data", int'(rise_data), 'hA5);
    check("a5_latency", last_rise - last_k, 79);

    // T3: sweep plus random back-to-back
    r0 = n_rise; f0 = n_ferr; o0 = n_ovr;
    for (int i = 0; i < 256; i++) send(8'(i), 1'b1, 0);
    for (int i = 0; i < 255; i++) send(8'($urandom), 1'b1, 0);
    tick(4);
    check("sweep_count", n_rise - r0, 511);
    check("sweep_ferr", n_ferr - f0, 0);
    check("sweep_ovr", n_ovr - o0, 0);

    // T4: short low glitch rejected, next frame good
    r0 = n_rise; f0 = n_ferr;
    glitch(2);
    check("glitch_no_valid", n_rise - r0, 0);
    check("glitch_no_ferr", n_ferr - f0, 0);
    send(8'h3C, 1'b1, 0);
    tick(4);
    check("3c_data", int'(rise_data), 'h3C);

    // T5: bad stop bit followed by a held-low break
    r0 = n_rise; f0 = n_ferr;
    send(8'h81, 1'b0, 3 * BIT);
    check("ferr_pulses", n_ferr - f0, 1);
    check("ferr_no_valid", n_rise - r0, 0);

    // random ready with occasional bad stop bits
    ready_mode = 2;
    for (int i = 0; i < 40; i++) send(8'($urandom), ($urandom_range(0, 7) != 0), $urandom_range(0, 2 * BIT));
    ready_mode = 1;
    tick(4);

    // T6: overrun with consumer stalled
    ready_mode = 0;
    tick(2);
    o0 = n_ovr;
    send(8'h11, 1'b1, 0);
    send(8'h22, 1'b1, 0);
    tick(2);
    check("ovr_pulses", n_ovr - o0, 1);
    check("ovr_data_held", int'(rx_data), 'h11);
    check("ovr_valid_held", int'(rx_valid), 1);
    ready_mode = 1;
    tick(3);
    check("ovr_valid_drop", int'(rx_valid), 0);

    // reset mid-byte aborts the frame silently
    r0 = n_rise; f0 = n_ferr; o0 = n_ovr;
    rs232_rx = 1'b0;
    busy_lo = cyc + 3;
    busy_hi = cyc + LAT;
    tick(3 * BIT + 2);
    check("busy_mid_frame", int'(rx_busy), 1);
    rst_n = 1'b0;
    rs232_rx = 1'b1;
    tick(3);
    check("rst_busy", int'(rx_busy), 0);
    rst_n = 1'b1;
    tick(2 * LAT);
    check("rst_no_output", (n_rise - r0) + (n_ferr - f0) + (n_ovr - o0), 0);
    check("events_drained", evq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #(10 * 95_000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

endmodule
